// File: rtl/axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : axi_pkg                                                      |
// | Description : Shared AXI4 encodings (burst type, response code), the read  |
// |               responder state type and burst legality helpers.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_BEAT = 2'd2
   } rd_state_e;

   // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // A burst whose shape cannot be served answers SLVERR on every beat.
   function automatic logic burst_illegal(input logic [7:0] len,
                                          input logic [2:0] size,
                                          input logic [1:0] burst);
      return (size > 3'd3) ||
             (burst == 2'b11) ||
             ((burst == BURST_WRAP) && !wrap_len_ok(len));
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_read_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : axi_read_responder_if                                        |
// | Description : AXI4 read address / read data channels.                      |
// |   AR: arvalid, arready, araddr[63:0], arlen[7:0], arsize[2:0], arburst[1:0]|
// |   R : rvalid, rready, rdata[63:0], rresp[1:0], rlast                       |
// |   master modport drives requests, slave modport answers them.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface axi_read_responder_if;
   logic        arvalid;
   logic        arready;
   logic [63:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   modport master (
      output arvalid, araddr, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_burst_addr_gen                                           |
// | Description : Combinational AXI4 next-beat address for FIXED/INCR/WRAP.    |
// |   i_addr[63:0]  current beat byte address                                  |
// |   i_len[7:0]    beats minus one                                            |
// |   i_size[2:0]   log2 bytes per beat                                        |
// |   i_burst[1:0]  burst type                                                 |
// |   o_next_addr   address of the following beat                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_burst_addr_gen
   import axi_pkg::*;
(
   input  wire logic [63:0] i_addr,
   input  wire logic [7:0]  i_len,
   input  wire logic [2:0]  i_size,
   input  wire logic [1:0]  i_burst,
   output logic      [63:0] o_next_addr
);

   logic [63:0] w_incr;
   logic [63:0] w_seq;
   logic [63:0] w_wrap_mask;

   always_comb begin
      w_incr      = 64'd1 << i_size;
      w_seq       = i_addr + w_incr;
      // Wrap window is (len+1) beats of 2^size bytes, aligned to its own size.
      w_wrap_mask = (({56'd0, i_len} + 64'd1) << i_size) - 64'd1;
      case (i_burst)
         BURST_FIXED: o_next_addr = i_addr;
         BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_seq & w_wrap_mask);
         default:     o_next_addr = w_seq;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/axi_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_read_responder                                           |
// | Description : AXI4 read subordinate backed by a 64-bit word memory, with a |
// |               backdoor write port for preloading images.                   |
// |   clk, reset    clock, synchronous active-high reset                       |
// |   s_axi         AR/R channels (slave modport)                              |
// |   mem_we        backdoor write enable                                      |
// |   mem_waddr     backdoor byte address (low 3 bits ignored)                 |
// |   mem_wdata     backdoor write data                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_read_responder
   import axi_pkg::*;
#(
   parameter int          MEM_WORDS    = 4096,
   parameter logic [63:0] BASE_ADDR    = 64'h0,
   parameter int          READ_LATENCY = 2
) (
   input  wire logic        clk,
   input  wire logic        reset,
   axi_read_responder_if.slave s_axi,
   input  wire logic        mem_we,
   input  wire logic [63:0] mem_waddr,
   input  wire logic [63:0] mem_wdata
);

   localparam int          c_IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [63:0] c_MEM_WORDS = 64'(MEM_WORDS);
   localparam logic [3:0]  c_LAT_LOAD  = 4'((READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0);

   rd_state_e   r_state;
   rd_state_e   w_state_next;

   logic [63:0] r_addr;
   logic [7:0]  r_len;
   logic [7:0]  r_beat;
   logic [2:0]  r_size;
   logic [1:0]  r_burst;
   logic        r_slverr;
   logic [3:0]  r_lat;

   logic        r_arready;
   logic        r_rvalid;
   logic        r_rlast;
   logic [63:0] r_rdata;
   logic [1:0]  r_rresp;

   logic [63:0] r_mem [MEM_WORDS];

   logic        w_ar_hs;
   logic        w_r_hs;
   logic        w_ar_slverr;
   logic [63:0] w_next_addr;

   logic        w_load;
   logic        w_load_last;
   logic        w_load_slverr;
   logic [63:0] w_load_addr;
   logic        w_done;

   logic [63:0] w_rd_off;
   logic [63:0] w_rd_word;
   logic        w_rd_in_range;
   logic [c_IDX_W-1:0] w_rd_idx;

   logic [63:0] w_wr_off;
   logic [63:0] w_wr_word;
   logic        w_wr_in_range;
   logic [c_IDX_W-1:0] w_wr_idx;

   assign s_axi.arready = r_arready;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rlast   = r_rlast;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;

   // arready is registered and only ever high in IDLE.
   assign w_ar_hs     = s_axi.arvalid && r_arready;
   assign w_r_hs      = r_rvalid && s_axi.rready;
   assign w_ar_slverr = burst_illegal(s_axi.arlen, s_axi.arsize, s_axi.arburst);

   axi_burst_addr_gen u_addr_gen (
      .i_addr      (r_addr),
      .i_len       (r_len),
      .i_size      (r_size),
      .i_burst     (r_burst),
      .o_next_addr (w_next_addr)
   );

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // w_load presents a new beat on R at the next edge; w_done retires the burst.
   always_comb begin
      w_state_next  = r_state;
      w_load        = 1'b0;
      w_load_last   = 1'b0;
      w_load_slverr = r_slverr;
      w_load_addr   = r_addr;
      w_done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ar_hs) begin
               if (READ_LATENCY == 0) begin
                  w_state_next  = ST_BEAT;
                  w_load        = 1'b1;
                  w_load_addr   = s_axi.araddr;
                  w_load_last   = (s_axi.arlen == 8'd0);
                  w_load_slverr = w_ar_slverr;
               end else begin
                  w_state_next  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (r_lat == 4'd0) begin
               w_state_next = ST_BEAT;
               w_load       = 1'b1;
               w_load_last  = (r_len == 8'd0);
            end
         end
         ST_BEAT: begin
            if (w_r_hs) begin
               if (r_beat == r_len) begin
                  w_state_next = ST_IDLE;
                  w_done       = 1'b1;
               end else begin
                  w_load       = 1'b1;
                  w_load_addr  = w_next_addr;
                  w_load_last  = ((r_beat + 8'd1) == r_len);
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ----------------------------------------------------- address decode ---
   always_comb begin
      w_rd_off      = w_load_addr - BASE_ADDR;
      w_rd_word     = w_rd_off >> 3;
      w_rd_in_range = (w_load_addr >= BASE_ADDR) && (w_rd_word < c_MEM_WORDS);
      w_rd_idx      = w_rd_word[c_IDX_W-1:0];

      w_wr_off      = mem_waddr - BASE_ADDR;
      w_wr_word     = w_wr_off >> 3;
      w_wr_in_range = (mem_waddr >= BASE_ADDR) && (w_wr_word < c_MEM_WORDS);
      w_wr_idx      = w_wr_word[c_IDX_W-1:0];
   end

   // ------------------------------------------------------- burst context ---
   always_ff @(posedge clk) begin
      if (reset) begin
         r_beat <= 8'd0;
         r_lat  <= 4'd0;
      end else begin
         if (w_ar_hs) begin
            r_addr   <= s_axi.araddr;
            r_len    <= s_axi.arlen;
            r_size   <= s_axi.arsize;
            r_burst  <= s_axi.arburst;
            r_slverr <= w_ar_slverr;
            r_beat   <= 8'd0;
            r_lat    <= c_LAT_LOAD;
         end else if ((r_state == ST_WAIT) && (r_lat != 4'd0)) begin
            r_lat    <= r_lat - 4'd1;
         end else if ((r_state == ST_BEAT) && w_load) begin
            r_addr   <= w_next_addr;
            r_beat   <= r_beat + 8'd1;
         end
      end
   end

   // ------------------------------------------------------ R channel regs ---
   // Memory is read with the pre-edge contents, so a beat loaded alongside a
   // backdoor write to the same word returns the old data.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rdata   <= 64'd0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_arready <= (w_state_next == ST_IDLE);
         if (w_load) begin
            r_rvalid <= 1'b1;
            r_rlast  <= w_load_last;
            if (w_load_slverr) begin
               r_rresp <= RESP_SLVERR;
               r_rdata <= 64'd0;
            end else if (!w_rd_in_range) begin
               r_rresp <= RESP_DECERR;
               r_rdata <= 64'd0;
            end else begin
               r_rresp <= RESP_OKAY;
               r_rdata <= r_mem[w_rd_idx];
            end
         end else if (w_done) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
      end
   end

   // Memory contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we && w_wr_in_range) begin
         r_mem[w_wr_idx] <= mem_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_read_responder                                        |
// | Description : Directed self-checking bench for axi_read_responder.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axi_read_responder;
   import axi_pkg::*;

   logic        clk;
   logic        reset;
   logic        mem_we;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;

   axi_read_responder_if bus ();

   axi_read_responder #(
      .MEM_WORDS    (4096),
      .BASE_ADDR    (64'h0),
      .READ_LATENCY (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .s_axi     (bus),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   logic [63:0] g_data [16];
   logic [1:0]  g_resp [16];
   logic        g_last [16];
   int          g_first;
   int          g_lastcyc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic bd_write(input int idx, input logic [63:0] data);
      mem_we    = 1'b1;
      mem_waddr = 64'(idx) << 3;
      mem_wdata = data;
      @(negedge clk);
      mem_we    = 1'b0;
   endtask

   // Leaves the bench at the negedge of cycle T+1, T being the AR handshake cycle.
   task automatic ar_issue(input logic [63:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
      int n;
      bus.arvalid = 1'b1;
      bus.araddr  = a;
      bus.arlen   = l;
      bus.arsize  = s;
      bus.arburst = b;
      n = 0;
      while (!bus.arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ar_ready_seen", 64'(bus.arready), 64'd1);
      @(negedge clk);
      bus.arvalid = 1'b0;
   endtask

   // pat 0: rready always high; pat 1: rready high one cycle in three.
   task automatic collect(input int maxbeats, input int pat);
      int          rel;
      int          got;
      bit          stalled;
      logic [63:0] sd;
      logic        sl;
      rel = 1; got = 0; stalled = 0; sd = '0; sl = 1'b0;
      g_first = -1; g_lastcyc = -1;
      while (got < maxbeats && rel < 200) begin
         bus.rready = (pat == 0) ? 1'b1 : ((rel % 3) == 0);
         if (bus.rvalid) begin
            if (g_first < 0) g_first = rel;
            if (stalled) begin
               check("hold_rdata", bus.rdata, sd);
               check("hold_rlast", 64'(bus.rlast), 64'(sl));
            end
            if (bus.rready) begin
               g_data[got] = bus.rdata;
               g_resp[got] = bus.rresp;
               g_last[got] = bus.rlast;
               got++;
               g_lastcyc = rel;
               stalled = 0;
            end else begin
               stalled = 1;
               sd = bus.rdata;
               sl = bus.rlast;
            end
         end
         @(negedge clk);
         rel++;
      end
      bus.rready = 1'b0;
      check("beat_count", 64'(got), 64'(maxbeats));
   endtask

   task automatic expect_beats(input string tag, input int n,
                               input logic [63:0] d0, input logic [63:0] d1,
                               input logic [63:0] d2, input logic [63:0] d3,
                               input logic [1:0] resp, input bit chk_data);
      logic [63:0] exp_d [4];
      exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
      for (int i = 0; i < n; i++) begin
         if (chk_data) check({tag, "_rdata"}, g_data[i], exp_d[i]);
         check({tag, "_rresp"}, 64'(g_resp[i]), 64'(resp));
         check({tag, "_rlast"}, 64'(g_last[i]), 64'(i == n - 1));
      end
      check({tag, "_idle_after"}, 64'(bus.rvalid), 64'd0);
   endtask

   initial begin
      reset       = 1'b1;
      mem_we      = 1'b0;
      mem_waddr   = '0;
      mem_wdata   = '0;
      bus.arvalid = 1'b0;
      bus.araddr  = '0;
      bus.arlen   = '0;
      bus.arsize  = '0;
      bus.arburst = '0;
      bus.rready  = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_arready", 64'(bus.arready), 64'd0);
      check("rst_rvalid",  64'(bus.rvalid),  64'd0);
      check("rst_rlast",   64'(bus.rlast),   64'd0);
      check("rst_rdata",   bus.rdata,        64'd0);
      check("rst_rresp",   64'(bus.rresp),   64'd0);

      reset = 1'b0;
      for (int i = 0; i < 8; i++) bd_write(i, 64'h1000 + 64'(i));
      bd_write(4095, 64'hF00D);
      check("idle_arready", 64'(bus.arready), 64'd1);

      // INCR, 4 beats, full rready
      ar_issue(64'h0, 8'd3, 3'd3, BURST_INCR);
      check("incr_arready_busy", 64'(bus.arready), 64'd0);
      collect(4, 0);
      check("incr_first_rvalid", 64'(g_first), 64'd3);
      check("incr_last_cycle", 64'(g_lastcyc), 64'd6);
      check("incr_arready_back", 64'(bus.arready), 64'd1);
      expect_beats("incr", 4, 64'h1000, 64'h1001, 64'h1002, 64'h1003, RESP_OKAY, 1);

      // WRAP from 0x10 over a 32-byte window
      ar_issue(64'h10, 8'd3, 3'd3, BURST_WRAP);
      collect(4, 0);
      expect_beats("wrap", 4, 64'h1002, 64'h1003, 64'h1000, 64'h1001, RESP_OKAY, 1);

      // FIXED repeats the same word
      ar_issue(64'h18, 8'd2, 3'd3, BURST_FIXED);
      collect(3, 0);
      expect_beats("fixed", 3, 64'h1003, 64'h1003, 64'h1003, 64'h0, RESP_OKAY, 1);

      // INCR under backpressure
      ar_issue(64'h0, 8'd3, 3'd3, BURST_INCR);
      collect(4, 1);
      expect_beats("bp", 4, 64'h1000, 64'h1001, 64'h1002, 64'h1003, RESP_OKAY, 1);

      // Run off the end of memory
      ar_issue(64'h7FF8, 8'd1, 3'd3, BURST_INCR);
      collect(2, 0);
      check("edge_b0_rdata", g_data[0], 64'hF00D);
      check("edge_b0_rresp", 64'(g_resp[0]), 64'(RESP_OKAY));
      check("edge_b0_rlast", 64'(g_last[0]), 64'd0);
      check("edge_b1_rdata", g_data[1], 64'h0);
      check("edge_b1_rresp", 64'(g_resp[1]), 64'(RESP_DECERR));
      check("edge_b1_rlast", 64'(g_last[1]), 64'd1);

      // Illegal burst shapes: full length, SLVERR throughout
      ar_issue(64'h0, 8'd2, 3'd4, BURST_INCR);
      collect(3, 0);
      expect_beats("size4", 3, 64'h0, 64'h0, 64'h0, 64'h0, RESP_SLVERR, 0);
      ar_issue(64'h0, 8'd2, 3'd3, 2'b11);
      collect(3, 0);
      expect_beats("burst11", 3, 64'h0, 64'h0, 64'h0, 64'h0, RESP_SLVERR, 0);
      ar_issue(64'h0, 8'd2, 3'd3, BURST_WRAP);
      collect(3, 0);
      expect_beats("wraplen", 3, 64'h0, 64'h0, 64'h0, 64'h0, RESP_SLVERR, 0);

      // Reset while beat 2 of an 8-beat burst is on the bus
      ar_issue(64'h0, 8'd7, 3'd3, BURST_INCR);
      collect(2, 0);
      check("mid_beat2_rvalid", 64'(bus.rvalid), 64'd1);
      check("mid_beat2_rdata", bus.rdata, 64'h1002);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_rvalid", 64'(bus.rvalid), 64'd0);
      check("mid_rst_arready", 64'(bus.arready), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_arready", 64'(bus.arready), 64'd1);
      ar_issue(64'h8, 8'd0, 3'd3, BURST_INCR);
      collect(1, 0);
      check("single_first_rvalid", 64'(g_first), 64'd3);
      expect_beats("single", 1, 64'h1001, 64'h0, 64'h0, 64'h0, RESP_OKAY, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
- AXI4 read-channel subordinate (responder) backed by a 64-bit-word memory array.
- Serves the AR/R bursts issued by the instruction-fetch cache: one address handshake, then arlen+1 data beats with rlast on the final beat.
- Used as the memory model in core-level benches and as on-chip boot ROM/RAM.
- Includes a backdoor write port for preloading program images.

Parameters:
- MEM_WORDS, 4096: depth of the memory in 64-bit words.
- BASE_ADDR, 64'h0: byte address that maps to word 0.
- READ_LATENCY, 2: idle cycles between the AR handshake and the first rvalid (0..15).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  64  burst start byte address.
- s_axi_arlen  in  8  beats minus one.
- s_axi_arsize  in  3  log2 bytes per beat.
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_rdata  out  64  read data.
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- s_axi_rlast  out  1  last beat of burst.
- mem_we  in  1  backdoor write enable.
- mem_waddr  in  64  backdoor byte address; 8-byte aligned, low 3 bits ignored.
- mem_wdata  in  64  backdoor write data.

Behaviour:
- Reset is synchronous and active-high (reset, synchronous, active-high).
  - Reset values: arready=0, rvalid=0, rlast=0, rdata=0, rresp=00; state returns to IDLE.
  - Reset mid-burst abandons the burst immediately; the memory contents are not cleared.
- State machine has three states: IDLE, WAIT, BEAT.
- IDLE:
  - arready=1.
  - On arvalid&&arready, capture araddr/arlen/arsize/arburst and load the beat counter to 0.
  - If READ_LATENCY=0, go to BEAT; otherwise go to WAIT and load the latency counter.
- WAIT:
  - arready=0.
  - Count down READ_LATENCY cycles, then go to BEAT.
  - If the AR handshake occurs at cycle T, the first rvalid is asserted at cycle T+1+READ_LATENCY.
- BEAT:
  - arready=0 and rvalid=1.
  - rdata, rresp and rlast are registered and held stable while rvalid&&!rready.
  - On rvalid&&rready:
    - If beat==arlen, go to IDLE; arready rises the next cycle (no AR accepted in the same cycle as the last R handshake).
    - Otherwise increment beat and advance the address; the next beat is presented the following cycle.
  - With rready held high, beats stream at 1 per cycle.
- rlast = (beat == arlen). A single-beat burst (arlen=0) asserts rvalid and rlast together.
- Address advance:
  - FIXED: the address is unchanged.
  - INCR: addr += (1<<arsize).
  - WRAP: the wrap boundary is ((arlen+1)<<arsize) bytes, aligned; the address increments and wraps to the aligned boundary start.
- Data: word index = (addr - BASE_ADDR) >> 3. rdata is the full aligned 64-bit word; narrow beats (arsize<3) are not lane-shifted.
- Errors (per beat):
  - Word index >= MEM_WORDS, or addr < BASE_ADDR: rresp=11 and rdata=0.
  - arsize>3: SLVERR on all beats.
  - WRAP with arlen not in {1,3,7,15}: SLVERR on all beats.
  - Reserved arburst=11: SLVERR on all beats.
  - An error never shortens the burst; exactly arlen+1 beats are always returned.
- Backdoor write:
  - Writes the memory on the clock edge when mem_we=1. Out-of-range writes are ignored.
  - A beat loaded in the same cycle as a write to the same word returns the old data; later beats see the new data.
- Only one outstanding burst at a time; arvalid is ignored outside IDLE.

Decomposition:
- Shared package axi_pkg:
  - Burst encodings: BURST_FIXED, BURST_INCR, BURST_WRAP.
  - Response encodings: RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - Responder state enum.
- Sub-module axi_burst_addr_gen:
  - Combinational next-address computation from addr, arlen, arsize and arburst.
  - Shared with the future write responder.

Test Plan:
- Preload words 0..7 with 64'h1000+i, READ_LATENCY=2. INCR read with araddr=0x0, arlen=3, arsize=3, rready=1 -> AR handshake at T; rvalid at T+3..T+6 with rdata 0x1000..0x1003; rlast at T+6; rresp=00; arready high at T+7.
- WRAP read with araddr=0x10, arlen=3, arsize=3 -> rdata 0x1002, 0x1003, 0x1000, 0x1001.
- Backpressure: the INCR burst above with rready toggled 1,0,0,1,... -> each beat's rdata/rlast held while stalled; no beat lost or duplicated.
- Burst starting at the last valid word, (MEM_WORDS-1)*8, with arlen=1 -> beat 0 rresp=00; beat 1 rresp=11 with rdata=0; rlast on beat 1.
- arsize=4 with arlen=2 -> 3 beats, all rresp=10. arburst=11 -> same response.
- Assert reset during beat 2 of an arlen=7 burst -> rvalid=0 the next cycle. After reset deassert, arready=1 and a new arlen=0 read returns a single beat with rlast=1.
